// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and FSM state type for the FIFO write arbiter
// Contents: ADDR_WIDTH_DEF, DATA_WIDTH_DEF, arb_state_e (IDLE, BURST).
package fifo_pkg;

    localparam int ADDR_WIDTH_DEF = 9;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic {
        IDLE  = 1'b0,   // arbitrate among requesters
        BURST = 1'b1    // granted requester owns the write port
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO-side bundle of the write arbiter
// Signals: wr_req, wr_data_in, wr_ack, gnt (requester side);
//          f_full, w_en, w_data (FIFO write-pointer side).
// Modports: master = arbiter, slave = requesters plus FIFO.
interface fifo_wr_arbiter_if
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic [NUM_REQ-1:0]            wr_req;
    logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_in;
    logic [NUM_REQ-1:0]            wr_ack;
    logic [NUM_REQ-1:0]            gnt;
    logic                          f_full;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         w_data;

    modport master (
        input  wr_req, wr_data_in, f_full,
        output wr_ack, gnt, w_en, w_data
    );

    modport slave (
        output wr_req, wr_data_in, f_full,
        input  wr_ack, gnt, w_en, w_data
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// rtl/fifo_wr_arbiter_rr_arbiter.sv - combinational round-robin winner selection
// Ports: req_i (request vector), ptr_i (highest-priority index),
//        gnt_o (one-hot winner, zero if no request), idx_o (winner index).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk offsets from farthest to nearest so the requester closest to
    // ptr_i (in wrap-around order) is the last writer and therefore wins.
    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = int'(ptr_i) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (req_i[cand_idx]) begin
                gnt_o           = '0;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for N requesters onto one FIFO write port
// Ports: w_clk (write clock), wrst (sync active-high reset),
//        bus (fifo_wr_arbiter_if.master: wr_req, wr_data_in, wr_ack, gnt, f_full, w_en, w_data),
//        wr_cnt (per-requester accepted-word counters, only with FIFO_WR_ARB_STATS_EN).
// Option macro: FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                    w_clk,
    input  logic                    wrst,
    fifo_wr_arbiter_if.master       bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]   wr_cnt
`endif
);

    localparam int         IDX_W    = $clog2(NUM_REQ);
    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ out of range 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("MAX_BURST out of range 1..255");
    end
    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("ADDR_WIDTH must be positive");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;

    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               req_g;
    logic               w_en_c;
    logic [NUM_REQ-1:0] ack_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i (bus.wr_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_onehot),
        .idx_o (win_idx)
    );

    // Write path is combinational from the requester so an accepted word
    // reaches the FIFO in the same cycle; reset gates it off immediately.
    assign req_g  = bus.wr_req[gidx_q];
    assign w_en_c = (state_q == BURST) && req_g && !bus.f_full && !wrst;
    assign ack_c  = w_en_c ? gnt_q : '0;

    assign bus.w_en   = w_en_c;
    assign bus.wr_ack = ack_c;
    assign bus.gnt    = gnt_q;
    assign bus.w_data = bus.wr_data_in[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.wr_req) begin
                    state_d     = BURST;
                    gnt_d       = win_onehot;
                    gidx_d      = win_idx;
                    burst_cnt_d = '0;
                end else begin
                    gnt_d = '0;
                end
            end
            BURST: begin
                // A dropped request ends the burst even on what would have
                // been its final beat; f_full alone only stalls.
                if (!req_g || (w_en_c && burst_cnt_q == LAST_CNT)) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    burst_cnt_d = '0;
                    rr_ptr_d    = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                end else if (w_en_c) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (wrst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    always_ff @(posedge w_clk) begin
        if (wrst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack_c[i] && cnt_q[i] != 16'hFFFF) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_wr_cnt
        assign wr_cnt[gi*16 +: 16] = cnt_q[gi];
    end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 9: FIFO address width, carried for pointer-width consistency with the write-pointer logic.
REQ-002 Parameter DATA_WIDTH, default 32: width of each write data word.
REQ-003 Parameter NUM_REQ, default 4: number of write requesters, range 2..8.
REQ-004 Parameter MAX_BURST, default 8: maximum words per grant, range 1..255.
REQ-005 Port w_clk, input, 1: the single write-domain clock; all logic is on its rising edge.
REQ-006 Port wrst, input, 1: reset, synchronous and active-high.
REQ-007 Port wr_req, input, NUM_REQ: bit i set means requester i presents a valid word.
REQ-008 Port wr_data_in, input, NUM_REQ*DATA_WIDTH: slice i is requester i's word.
REQ-009 Port wr_ack, output, NUM_REQ: bit i set means requester i's word is accepted this cycle.
REQ-010 Port gnt, output, NUM_REQ: one-hot current grant, or zero.
REQ-011 Port f_full, input, 1: full flag from the write-pointer logic.
REQ-012 Port w_en, output, 1: FIFO write enable.
REQ-013 Port w_data, output, DATA_WIDTH: FIFO write data.

Function
REQ-014 FSM states SHALL be IDLE (arbitrate) and BURST (granted requester owns the write port).
REQ-015 In IDLE with wr_req nonzero, the arbiter SHALL pick a winner round-robin, starting from rr_ptr.
- Registers gnt one-hot to the winner.
- Clears burst_cnt.
- Enters BURST next cycle.
REQ-016 In IDLE with wr_req zero, the block SHALL hold gnt=0 and w_en=0.
REQ-017 In BURST, w_en SHALL be combinational: wr_req[g] & ~f_full, where g is the granted index.
- wr_ack[g] = w_en.
- All other wr_ack bits are 0.
- w_data = slice g of wr_data_in, with zero-cycle latency.
REQ-018 Each transfer (w_en=1) SHALL increment burst_cnt by 1.
REQ-019 BURST SHALL exit to IDLE on the cycle after either:
- a transfer with burst_cnt = MAX_BURST-1; or
- wr_req[g] = 0.
On exit: gnt clears and rr_ptr = (g+1) mod NUM_REQ.
REQ-020 While f_full=1 in BURST, w_en=0, burst_cnt holds and the grant is retained; f_full does not cause a timeout or exit.
REQ-021 IDLE always costs one cycle, so back-to-back grants have exactly one bubble.
REQ-022 w_en SHALL never assert in IDLE, and never while f_full=1.
REQ-023 rr_ptr SHALL wrap from NUM_REQ-1 to 0.
REQ-024 If wr_req[g] drops on the same cycle burst_cnt would reach MAX_BURST-1, it is treated as a drop: no transfer, exit to IDLE.

Reset
REQ-025 When wrst=1 at a w_clk edge, the block SHALL reset: state=IDLE, gnt=0, burst_cnt=0, rr_ptr=0 (requester 0 has first priority).
REQ-026 While wrst=1, w_en=0 and wr_ack=0 regardless of wr_req.
REQ-027 Reset mid-burst SHALL abort the burst; any word not acked before reset is not written.

Configuration
REQ-028 With FIFO_WR_ARB_STATS_EN defined, an output port wr_cnt (NUM_REQ x 16 bits) SHALL be added.
- Counts accepted words per requester.
- Saturates at 16'hFFFF.
- Cleared by wrst.
REQ-029 Without FIFO_WR_ARB_STATS_EN, wr_cnt and its counters SHALL not exist; all other behaviour is identical.

Structure
REQ-030 Shared package fifo_pkg SHALL hold:
- ADDR_WIDTH and DATA_WIDTH defaults;
- the arb_state_e enum (IDLE, BURST).
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_arbiter.
- Inputs: request vector, rr_ptr.
- Outputs: one-hot winner, winner index.
- The FSM, counters and datapath mux stay in fifo_wr_arbiter.

Verification
REQ-032 Reset: wrst=1 for 5 cycles with wr_req=4'b1111 -> gnt=0, w_en=0, wr_ack=0 throughout; after release, first gnt=4'b0001.
REQ-033 Round-robin: all four requesters continuously requesting, MAX_BURST=8, f_full=0.
- Grants rotate 0,1,2,3,0.
- Each burst has 8 w_en pulses.
- Exactly 1 idle cycle between bursts.
REQ-034 Full stall: mid-burst after 3 words, f_full=1 for 10 cycles.
- w_en=0 for all 10 cycles; gnt is unchanged.
- After release, exactly 5 more words are written.
REQ-035 Early drop: requester 2 alone, wr_req[2] deasserts after 3 acks -> BURST exits; next grant search starts at requester 3.
REQ-036 Data steering: requester i drives word 32'hA000_0000+i*16+n -> the w_data sequence matches the grant order exactly, with no word lost or duplicated.
REQ-037 Stats (FIFO_WR_ARB_STATS_EN): after REQ-033 runs for 2 full rotations -> each wr_cnt = 16.
